mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share
// one single-outstanding memory port. Data is favoured, but a waiting fetch
// is forced through after STREAK consecutive data grants.
module mem_port_arbiter #(
  parameter int STREAK = 3
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        if_req,
  input  logic [31:2] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:2] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,

  output logic        mem_en,
  output logic        mem_we,
  output logic [31:2] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SW = (STREAK < 1) ? 1 : $clog2(STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STREAK);

  state_t        r_state;
  logic          r_owner;       // 0 = fetch, 1 = data
  logic [SW-1:0] r_streak_cnt;
  logic          r_if_gnt;
  logic          r_d_gnt;
  logic          r_if_valid;
  logic          r_d_valid;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [31:2]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_d_rdata;

  logic          w_any_req;
  logic          w_fetch_wins;
  logic [SW-1:0] w_streak_nxt;

  assign w_any_req    = if_req | d_req;
  // A fetch wins when it is alone, or when data has used up its streak.
  assign w_fetch_wins = if_req && (!d_req || (r_streak_cnt == STREAK_MAX));

  // Streak counter value to load at an arbitration (IDLE) edge.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_streak_nxt = r_streak_cnt;
    if (!if_req || w_fetch_wins) begin
      w_streak_nxt = '0;
    end else if (r_streak_cnt != STREAK_MAX) begin
      w_streak_nxt = r_streak_cnt + SW'(1);
    end
  end

  // Arbitration FSM with registered grant/valid/memory outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the latched address/data and rdata registers are reset too, so
      // the memory port and read data read as zero while reset is held.
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_streak_cnt <= '0;
      r_if_gnt     <= 1'b0;
      r_d_gnt      <= 1'b0;
      r_if_valid   <= 1'b0;
      r_d_valid    <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of the others, regardless of statement order.
      r_if_gnt   <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;

      unique case (r_state)
        IDLE: begin
          r_streak_cnt <= w_streak_nxt;
          if (w_any_req) begin
            r_state  <= BUSY;
            r_mem_en <= 1'b1;
            if (w_fetch_wins) begin
              r_owner    <= 1'b0;
              r_if_gnt   <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= if_addr;
            end else begin
              r_owner     <= 1'b1;
              r_d_gnt     <= 1'b1;
              r_mem_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
            end
          end
        end

        BUSY: begin
          if (mem_ready) begin
            r_state  <= DONE;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_owner) begin
              r_d_valid <= 1'b1;
              // Stores return zero rather than whatever the memory drives.
              r_d_rdata <= r_mem_we ? 32'h0 : mem_rdata;
            end else begin
              r_if_valid <= 1'b1;
              r_if_rdata <= mem_rdata;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign if_valid  = r_if_valid;
  assign d_valid   = r_d_valid;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for the basic fetch,
// load and contended-store flows, then hand sequences for streak limiting,
// asynchronous reset, input changes mid-transaction and stray mem_ready.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:2] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:2] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:2] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.STREAK(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic        d_req;
    logic        d_we;
    logic [31:2] if_addr;
    logic [31:2] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_if_valid;
    logic        e_d_valid;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [31:2] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic [31:0] e_if_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  localparam logic [31:0] R1 = 32'h2402000A;
  localparam logic [31:0] R2 = 32'h0BADF00D;
  localparam logic [31:0] R3 = 32'hCAFE0001;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:2] A1 = 30'h100000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    // Vector fields: if_req d_req d_we if_addr d_addr d_wdata rdy rdata |
    //                if_gnt d_gnt if_valid d_valid en we addr wdata if_rdata d_rdata
    // Lone zero-wait fetch; request held through the DONE cycle.
    vecs[0]  = '{1'b1,1'b0,1'b0, A1,30'h0,32'h0, 1'b1,R1, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, A1,32'h0, 32'h0,32'h0};
    vecs[1]  = '{1'b1,1'b0,1'b0, A1,30'h0,32'h0, 1'b1,R1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, A1,32'h0, R1,32'h0};
    vecs[2]  = '{1'b1,1'b0,1'b0, A1,30'h0,32'h0, 1'b1,R1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, A1,32'h0, R1,32'h0};
    vecs[3]  = '{1'b0,1'b0,1'b0, 30'h0,30'h0,32'h0, 1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, A1,32'h0, R1,32'h0};
    // Lone data load so that d_rdata holds a nonzero word.
    vecs[4]  = '{1'b0,1'b1,1'b0, 30'h0,30'h80,32'h0, 1'b1,R2, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 30'h80,32'h0, R1,32'h0};
    vecs[5]  = '{1'b0,1'b1,1'b0, 30'h0,30'h80,32'h0, 1'b1,R2, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 30'h80,32'h0, R1,R2};
    vecs[6]  = '{1'b0,1'b0,1'b0, 30'h0,30'h0,32'h0, 1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 30'h80,32'h0, R1,R2};
    // Store and fetch together, two wait states: data first, store returns 0.
    vecs[7]  = '{1'b1,1'b1,1'b1, 30'h200,30'h4000,DB, 1'b0,32'h0, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 30'h4000,DB, R1,R2};
    vecs[8]  = '{1'b1,1'b1,1'b1, 30'h200,30'h4000,DB, 1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 30'h4000,DB, R1,R2};
    vecs[9]  = '{1'b1,1'b1,1'b1, 30'h200,30'h4000,DB, 1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 30'h4000,DB, R1,R2};
    vecs[10] = '{1'b1,1'b1,1'b1, 30'h200,30'h4000,DB, 1'b1,32'h12345678, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 30'h4000,DB, R1,32'h0};
    vecs[11] = '{1'b1,1'b0,1'b0, 30'h200,30'h0,32'h0, 1'b1,32'h12345678, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 30'h4000,DB, R1,32'h0};
    vecs[12] = '{1'b1,1'b0,1'b0, 30'h200,30'h0,32'h0, 1'b0,32'h0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 30'h200,DB, R1,32'h0};
    vecs[13] = '{1'b1,1'b0,1'b0, 30'h200,30'h0,32'h0, 1'b1,R3, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 30'h200,DB, R3,32'h0};
    vecs[14] = '{1'b0,1'b0,1'b0, 30'h0,30'h0,32'h0, 1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 30'h200,DB, R3,32'h0};

    idle_inputs();
    reset = 1'b0;
    #3;
    check("rst_if_gnt",   32'(if_gnt),   32'h0);
    check("rst_d_gnt",    32'(d_gnt),    32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_d_valid",  32'(d_valid),  32'h0);
    check("rst_mem_en",   32'(mem_en),   32'h0);
    check("rst_mem_we",   32'(mem_we),   32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_rdata",    if_rdata | d_rdata | mem_wdata, 32'h0);

    // Release between edges; the next rising edge is the first arbitration.
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if_req    = vecs[i].if_req;
      d_req     = vecs[i].d_req;
      d_we      = vecs[i].d_we;
      if_addr   = vecs[i].if_addr;
      d_addr    = vecs[i].d_addr;
      d_wdata   = vecs[i].d_wdata;
      mem_ready = vecs[i].mem_ready;
      mem_rdata = vecs[i].mem_rdata;
      step();
      check($sformatf("v%0d_if_gnt", i),    32'(if_gnt),    32'(vecs[i].e_if_gnt));
      check($sformatf("v%0d_d_gnt", i),     32'(d_gnt),     32'(vecs[i].e_d_gnt));
      check($sformatf("v%0d_if_valid", i),  32'(if_valid),  32'(vecs[i].e_if_valid));
      check($sformatf("v%0d_d_valid", i),   32'(d_valid),   32'(vecs[i].e_d_valid));
      check($sformatf("v%0d_mem_en", i),    32'(mem_en),    32'(vecs[i].e_mem_en));
      check($sformatf("v%0d_mem_we", i),    32'(mem_we),    32'(vecs[i].e_mem_we));
      check($sformatf("v%0d_mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_mem_addr));
      check($sformatf("v%0d_mem_wdata", i), mem_wdata,      vecs[i].e_mem_wdata);
      check($sformatf("v%0d_if_rdata", i),  if_rdata,       vecs[i].e_if_rdata);
      check($sformatf("v%0d_d_rdata", i),   d_rdata,        vecs[i].e_d_rdata);
    end

    // Held fetch against back-to-back loads: D D D F, then D again.
    idle_inputs();
    if_req    = 1'b1;
    if_addr   = 30'h300;
    d_req     = 1'b1;
    d_addr    = 30'h20;
    mem_ready = 1'b1;
    mem_rdata = 32'h55AA0000;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("s3_grant%0d", k), 32'({if_gnt, d_gnt}), (k == 3) ? 32'h2 : 32'h1);
      if (k == 2) check("s3_streak_sat", 32'(dut.r_streak_cnt), 32'd3);
      if (k == 3) check("s3_streak_clr", 32'(dut.r_streak_cnt), 32'd0);
      step();
      step();
    end
    check("s3_d_rdata", d_rdata, 32'h55AA0000);
    check("s3_if_rdata", if_rdata, 32'h55AA0000);
    idle_inputs();
    step();

    // Asynchronous reset in the middle of a BUSY cycle.
    d_req  = 1'b1;
    d_addr = 30'h40;
    step();
    check("s4_busy_gnt", 32'(d_gnt),  32'h1);
    check("s4_busy_en",  32'(mem_en), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("s4_rst_en",    32'(mem_en),   32'h0);
    check("s4_rst_gnt",   32'(d_gnt),    32'h0);
    check("s4_rst_addr",  32'(mem_addr), 32'h0);
    check("s4_rst_rdata", if_rdata | d_rdata, 32'h0);
    d_req     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h77777777;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("s4_no_valid%0d", k), 32'({if_valid, d_valid, mem_en}), 32'h0);
    end
    if_req  = 1'b1;
    if_addr = 30'h400;
    mem_rdata = 32'h13579BDF;
    step();
    check("s4_new_gnt",  32'(if_gnt),   32'h1);
    check("s4_new_addr", 32'(mem_addr), 32'h400);
    step();
    check("s4_new_valid", 32'(if_valid), 32'h1);
    check("s4_new_rdata", if_rdata, 32'h13579BDF);
    if_req = 1'b0;
    step();

    // Request dropped and address changed while BUSY.
    idle_inputs();
    d_req     = 1'b1;
    d_addr    = 30'h500;
    mem_rdata = 32'h0F0F0F0F;
    step();
    check("s5_gnt",  32'(d_gnt),    32'h1);
    check("s5_addr", 32'(mem_addr), 32'h500);
    d_req   = 1'b0;
    d_addr  = 30'h7FF;
    d_we    = 1'b1;
    d_wdata = 32'hFFFFFFFF;
    step();
    check("s5_addr_held",  32'(mem_addr), 32'h500);
    check("s5_we_held",    32'(mem_we),   32'h0);
    check("s5_wdata_held", mem_wdata,     32'h0);
    check("s5_still_busy", 32'(mem_en),   32'h1);
    mem_ready = 1'b1;
    step();
    check("s5_valid", 32'(d_valid), 32'h1);
    check("s5_rdata", d_rdata, 32'h0F0F0F0F);
    mem_ready = 1'b0;
    step();
    check("s5_valid_once", 32'({d_valid, mem_en}), 32'h0);
    step();
    check("s5_idle", 32'({d_valid, mem_en, d_gnt}), 32'h0);

    // Stray mem_ready in IDLE and in DONE.
    idle_inputs();
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    step();
    check("s6_idle_ready", 32'({if_valid, d_valid, mem_en}), 32'h0);
    check("s6_idle_rdata", if_rdata, 32'h13579BDF);
    if_req  = 1'b1;
    if_addr = 30'h600;
    step();
    check("s6_gnt", 32'(if_gnt), 32'h1);
    step();
    check("s6_valid", 32'(if_valid), 32'h1);
    if_req = 1'b0;
    step();
    check("s6_done_ready", 32'({if_valid, d_valid, mem_en}), 32'h0);
    mem_ready = 1'b0;
    step();
    check("s6_settled", 32'({if_valid, d_valid, mem_en, if_gnt, d_gnt}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, limit %0d", 100000);
    $fatal(1, "timeout");
  end

endmodule
